// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master side supplies operands and takes results; the slave side is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit carry-lookahead slice is reused once per
// nibble, LSB first, with the carry registered between nibbles.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_p0;
  logic             carry_p0;
  logic [WIDTH-1:0] a_p0, b_p0, acc_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1, ovf_p1;

  logic             accept, last;
  logic [5:0]       slice;
  logic [WIDTH-1:0] acc_next;

  // Returns {c3, c2, s[3:0]} where c[i] is the carry out of bit i.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p, c;
    g = x & y;
    p = x ^ y;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[3], c[2], p ^ {c[2:0], ci}};
  endfunction

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.sum       = sum_p1;
  assign bus.cout      = cout_p1;
  assign bus.ovf       = ovf_p1;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt_p0 == CW'(NIB - 1));
  assign slice  = cla4(a_p0[3:0], b_p0[3:0], carry_p0);

  always_comb begin
    acc_next = acc_p0 >> 4;
    acc_next[WIDTH-1 -: 4] = slice[3:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = bus.in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_p0   <= '0;
      carry_p0 <= 1'b0;
      sum_p1   <= '0;
      cout_p1  <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Stage p0: operand capture, then one nibble per RUN cycle.
      if (accept) begin
        a_p0     <= bus.a;
        b_p0     <= bus.b;
        carry_p0 <= bus.cin;
        cnt_p0   <= '0;
      end else if (state_q == RUN) begin
        a_p0     <= a_p0 >> 4;
        b_p0     <= b_p0 >> 4;
        acc_p0   <= acc_next;
        carry_p0 <= slice[5];
        cnt_p0   <= cnt_p0 + 1'b1;
        // Stage p1: result registers load only on the final nibble.
        if (last) begin
          sum_p1  <= acc_next;
          cout_p1 <= slice[5];
          ovf_p1  <= slice[5] ^ slice[4];
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH 4, 16 and 32: directed vectors plus a
// randomized handshake regression checked against a queue of expected results.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(4))  bus4();
  nibble_serial_adder_if #(.WIDTH(16)) bus16();
  nibble_serial_adder_if #(.WIDTH(32)) bus32();

  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  nibble_serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] sbq[$];   // {ovf, cout, sum zero-extended to 32 bits}

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic iv, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input logic ordy);
    case (w)
      4: begin
        bus4.in_valid = iv; bus4.a = a[3:0]; bus4.b = b[3:0];
        bus4.cin = cin; bus4.out_ready = ordy;
      end
      16: begin
        bus16.in_valid = iv; bus16.a = a[15:0]; bus16.b = b[15:0];
        bus16.cin = cin; bus16.out_ready = ordy;
      end
      default: begin
        bus32.in_valid = iv; bus32.a = a; bus32.b = b;
        bus32.cin = cin; bus32.out_ready = ordy;
      end
    endcase
  endtask

  task automatic sample(input int w, output logic ir, output logic ov, output logic bsy,
                        output logic [33:0] res);
    case (w)
      4: begin
        ir = bus4.in_ready; ov = bus4.out_valid; bsy = bus4.busy;
        res = {bus4.ovf, bus4.cout, 28'h0, bus4.sum};
      end
      16: begin
        ir = bus16.in_ready; ov = bus16.out_valid; bsy = bus16.busy;
        res = {bus16.ovf, bus16.cout, 16'h0, bus16.sum};
      end
      default: begin
        ir = bus32.in_ready; ov = bus32.out_valid; bsy = bus32.busy;
        res = {bus32.ovf, bus32.cout, bus32.sum};
      end
    endcase
  endtask

  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    longint unsigned mask, full, s;
    logic co, ov, sa, sb, ss;
    mask = (64'd1 << w) - 1;
    full = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
    s    = full & mask;
    co   = full[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = s[w-1];
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, s[31:0]};
  endfunction

  // Accept one 16-bit operation, wait for the result and compare it with the queue head.
  task automatic run_vec(input vec_t v, input string tag, input bit consume);
    logic ir, ov, bsy;
    logic [33:0] res, exp;
    int cyc, busy_cnt;
    drive(16, 1'b1, {16'h0, v.a}, {16'h0, v.b}, v.cin, 1'b0);
    #1;
    sample(16, ir, ov, bsy, res);
    check({tag, "_in_ready"}, 64'(ir), 64'd1);
    sbq.push_back({v.ovf, v.cout, 16'h0, v.sum});
    step();
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc = 0;
    busy_cnt = 0;
    sample(16, ir, ov, bsy, res);
    while (!ov && cyc < 20) begin
      if (bsy) busy_cnt++;
      step();
      cyc++;
      sample(16, ir, ov, bsy, res);
    end
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    exp = (sbq.size() > 0) ? sbq.pop_front() : 34'h0;
    check({tag, "_result"}, 64'(res), 64'(exp));
    if (consume) begin
      drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step();
      drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      sample(16, ir, ov, bsy, res);
      check({tag, "_out_valid_drop"}, 64'(ov), 64'd0);
    end
  endtask

  task automatic rand_run(input int w, input int n);
    int sent, got, cyc;
    logic iv, ordy, ir, ov, bsy, rc;
    logic [31:0] ra, rb;
    logic [33:0] res, exp;
    sent = 0;
    got = 0;
    cyc = 0;
    sbq.delete();
    while ((sent < n || sbq.size() > 0) && cyc < n * 30) begin
      iv   = (sent < n) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0) || (sent >= n);
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(7) == 0) rb = {1'b1, 31'h0} >> (32 - w);
      drive(w, iv, ra, rb, rc, ordy);
      #1;
      sample(w, ir, ov, bsy, res);
      if (ov && ordy) begin
        if (sbq.size() == 0) begin
          check($sformatf("rand%0d_unexpected_result", w), 64'd1, 64'd0);
        end else begin
          exp = sbq.pop_front();
          check($sformatf("rand%0d_result_%0d", w, got), 64'(res), 64'(exp));
          got++;
        end
      end
      if (iv && ir) begin
        sbq.push_back(model(w, ra, rb, rc));
        sent++;
      end
      step();
      cyc++;
    end
    drive(w, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check($sformatf("rand%0d_result_count", w), 64'(got), 64'(n));
    check($sformatf("rand%0d_queue_left", w), 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t v;
    logic ir, ov, bsy;
    logic [33:0] res;
    int cyc;

    vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b1};

    rst_n = 1'b0;
    drive(4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(32, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    sample(16, ir, ov, bsy, res);
    check("reset_in_ready", 64'(ir), 64'd1);
    check("reset_out_valid", 64'(ov), 64'd0);
    check("reset_busy", 64'(bsy), 64'd0);
    check("reset_result", 64'(res), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

    // Backpressure: result held in DONE while in_valid pulses.
    v = '{a: 16'h00AA, b: 16'h0055, cin: 1'b0, sum: 16'h00FF, cout: 1'b0, ovf: 1'b0};
    run_vec(v, "bp_first", 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(16, 1'(i % 2 == 0), 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
      #1;
      sample(16, ir, ov, bsy, res);
      check($sformatf("bp_hold_out_valid_%0d", i), 64'(ov), 64'd1);
      check($sformatf("bp_hold_in_ready_%0d", i), 64'(ir), 64'd0);
      check($sformatf("bp_hold_result_%0d", i), 64'(res), 64'h00FF);
      step();
    end
    drive(16, 1'b1, 32'h0001, 32'h0002, 1'b0, 1'b1);
    #1;
    sample(16, ir, ov, bsy, res);
    check("bp_b2b_in_ready", 64'(ir), 64'd1);
    sbq.push_back({2'b00, 32'h0003});
    step();
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    sample(16, ir, ov, bsy, res);
    check("bp_b2b_busy", 64'(bsy), 64'd1);
    check("bp_b2b_out_valid", 64'(ov), 64'd0);
    check("bp_b2b_held_result", 64'(res), 64'h00FF);
    cyc = 0;
    while (!ov && cyc < 20) begin
      step();
      cyc++;
      sample(16, ir, ov, bsy, res);
    end
    check("bp_b2b_latency", 64'(cyc), 64'd4);
    check("bp_b2b_result", 64'(res), 64'(sbq.pop_front()));
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset during the second RUN cycle discards the operation.
    drive(16, 1'b1, 32'h1111, 32'h1111, 1'b1, 1'b0);
    step();
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    sample(16, ir, ov, bsy, res);
    check("midrst_out_valid", 64'(ov), 64'd0);
    check("midrst_busy", 64'(bsy), 64'd0);
    check("midrst_result", 64'(res), 64'd0);
    check("midrst_in_ready", 64'(ir), 64'd1);
    rst_n = 1'b1;
    v = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, sum: 16'h0100, cout: 1'b0, ovf: 1'b0};
    run_vec(v, "post_rst", 1'b1);

    // WIDTH=4: a single RUN cycle.
    drive(4, 1'b1, 32'h9, 32'h8, 1'b1, 1'b0);
    step();
    drive(4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    sample(4, ir, ov, bsy, res);
    check("w4_busy", 64'(bsy), 64'd1);
    step();
    sample(4, ir, ov, bsy, res);
    check("w4_out_valid", 64'(ov), 64'd1);
    check("w4_result", 64'(res), 64'({2'b11, 32'h2}));
    drive(4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    drive(4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    rand_run(16, 1000);
    rand_run(32, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
